tx_chunk_scheduler: RTL
=======================

// Module: tx_chunk_scheduler
// PURPOSE
//  Round-robin scheduler that shares the single uart_tx_typed_chunker among NUM_REQ virtual interfaces (leds, display, ...).
//  Samples each interface's should_update and typed chunk, loads the winner into the chunker and pulses its ack (interface reset).
//  Waits for is_chunker_done, then returns to arbitration. Replaces the hard-coded per-interface sequence in min_os.
// PARAMETERS
//  NUM_REQ           4   number of requesting virtual interfaces (>=2)
//  MAX_BYTES         5   chunker content buffer size in bytes (= TX_CONTENT_BUFFER_BYTE_SIZE)
//  INDEX_SIZE        32  width of chunk byte-size fields (= TX_CONTENT_BUFFER_INDEX_SIZE)
//  TIMEOUT_CYCLES    0   max cycles in WAIT before abort; 0 disables the watchdog
// PORTS
//  CLK                 in   1                     system clock, all logic on posedge
//  reset_n             in   1                     asynchronous active-low reset
//  req                 in   NUM_REQ               per-interface should_update level
//  req_chunk_type      in   NUM_REQ*8             packed chunk types, requester i at [i*8 +: 8]
//  req_chunk_bytes     in   NUM_REQ*MAX_BYTES*8   packed payloads, requester i at [i*MAX_BYTES*8 +: MAX_BYTES*8]
//  req_byte_size       in   NUM_REQ*INDEX_SIZE    packed payload lengths in bytes
//  ack                 out  NUM_REQ               one-cycle pulse to granted interface (drives its reset)
//  tx_is_chunk_ready   out  1                     one-cycle load strobe to chunker
//  tx_chunk_type       out  8                     registered chunk type to chunker
//  tx_chunk_bytes      out  MAX_BYTES*8           registered payload to chunker
//  tx_chunk_byte_size  out  INDEX_SIZE            registered length; non-zero only during strobe cycle
//  tx_is_chunker_done  in   1                     chunker completion pulse
//  busy                out  1                     high in any state other than IDLE
//  grant_id            out  $clog2(NUM_REQ)       index of last granted requester
//  size_err            out  1                     one-cycle pulse: granted request had illegal size
//  timeout_err         out  1                     one-cycle pulse: watchdog expired in WAIT
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; all outputs 0; grant_id=NUM_REQ-1 (requester 0 has first priority); timer 0.
//  - States: IDLE -> GRANT -> HOLD -> WAIT -> IDLE. All outputs are registered.
//  - IDLE: if |req, go GRANT next cycle; otherwise stay.
//  - GRANT: winner = first i with req[i]=1, searching from (grant_id+1) mod NUM_REQ upward, wrapping.
//      grant_id<=winner; ack[winner]<=1. If winner's size==0 or >MAX_BYTES: size_err<=1, no strobe, next IDLE.
//      Else: latch type/bytes/size, tx_is_chunk_ready<=1, next HOLD.
//      If req drops to 0 between IDLE and GRANT: return IDLE, no ack, grant_id unchanged.
//  - HOLD: tx_is_chunk_ready<=0, tx_chunk_byte_size<=0, ack<=0, timer<=0, next WAIT.
//      tx_chunk_type/bytes hold their values until the next load.
//  - WAIT: on tx_is_chunker_done -> IDLE. Else timer++. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1:
//      timeout_err<=1, next IDLE.
//  - Latency: req sampled high in IDLE at cycle n -> strobe + ack high exactly in cycle n+2, for one cycle.
//  - tx_is_chunker_done is honoured only in WAIT; a done pulse in IDLE/GRANT/HOLD is ignored.
//  - Request changes after GRANT do not affect the chunk in flight. A still-high req re-arbitrates normally.
//  - Exactly one ack bit is ever high at a time. size_err/timeout_err never assert together.
//  - reset_n asserted mid-transfer: immediate IDLE. The in-flight chunk is abandoned; no ack or err is emitted.
// TESTING
//  1. Reset, req=4'b0001, type=2, bytes=8'hA5, size=1 -> cycle n+2: strobe=1, ack=0001, type=2, size=1;
//     n+3: strobe=0, size=0; done -> IDLE.
//  2. req=4'b1111 held, done 10 cycles after each strobe -> grant_id sequence 0,1,2,3,0; one ack per chunk.
//  3. grant_id=2, req=4'b0011 -> winner 0 (wrap), not 1.
//  4. req[1] with size=0, then with size=6 (MAX_BYTES=5) -> ack[1] and size_err pulse each time, strobe stays 0, back to IDLE.
//  5. TIMEOUT_CYCLES=16, done never asserted -> timeout_err pulses 16 cycles after HOLD, busy drops next cycle.
//  6. reset_n low during WAIT, done pulse in IDLE -> outputs 0 at once, grant_id=3; stray done causes no transition.

Source files
------------

// File: rtl/tx_chunk_scheduler.sv
// Round-robin scheduler sharing one typed-chunk UART transmitter among NUM_REQ
// virtual interfaces: arbitrate, load the winner's chunk, ack it, wait for the chunker.
module tx_chunk_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BYTES      = 5,
  parameter int INDEX_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                              CLK,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*8-1:0]              req_chunk_type,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0]    req_chunk_bytes,
  input  logic [NUM_REQ*INDEX_SIZE-1:0]     req_byte_size,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              tx_is_chunk_ready,
  output logic [7:0]                        tx_chunk_type,
  output logic [MAX_BYTES*8-1:0]            tx_chunk_bytes,
  output logic [INDEX_SIZE-1:0]             tx_chunk_byte_size,
  input  logic                              tx_is_chunker_done,
  output logic                              busy,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              size_err,
  output logic                              timeout_err
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         TMAX     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [INDEX_SIZE-1:0] MAX_SIZE = INDEX_SIZE'(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t state;
  logic [TW-1:0] timer;

  logic                     found;
  logic [GID_W-1:0]         winner;
  logic [NUM_REQ-1:0]       win_onehot;
  logic [7:0]               sel_type;
  logic [MAX_BYTES*8-1:0]   sel_bytes;
  logic [INDEX_SIZE-1:0]    sel_size;
  logic                     size_bad;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found      = 1'b0;
    winner     = grant_id;
    win_onehot = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      logic [GID_W-1:0] idx;
      idx = GID_W'((32'(grant_id) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found           = 1'b1;
        winner          = idx;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    int unsigned w;
    w         = 32'(winner);
    sel_type  = req_chunk_type[w*8 +: 8];
    sel_bytes = req_chunk_bytes[w*MAX_BYTES*8 +: MAX_BYTES*8];
    sel_size  = req_byte_size[w*INDEX_SIZE +: INDEX_SIZE];
    size_bad  = (sel_size == '0) || (sel_size > MAX_SIZE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      timer              <= '0;
      ack                <= '0;
      tx_is_chunk_ready  <= 1'b0;
      tx_chunk_type      <= '0;
      tx_chunk_bytes     <= '0;
      tx_chunk_byte_size <= '0;
      busy               <= 1'b0;
      grant_id           <= GID_W'(NUM_REQ - 1);
      size_err           <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      // Pulse outputs default low; only the state that fires them raises them.
      ack                <= '0;
      tx_is_chunk_ready  <= 1'b0;
      tx_chunk_byte_size <= '0;
      size_err           <= 1'b0;
      timeout_err        <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= |req;
          if (|req) state <= S_GRANT;
        end
        S_GRANT: begin
          if (!found) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            grant_id <= winner;
            ack      <= win_onehot;
            if (size_bad) begin
              size_err <= 1'b1;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              tx_chunk_type      <= sel_type;
              tx_chunk_bytes     <= sel_bytes;
              tx_chunk_byte_size <= sel_size;
              tx_is_chunk_ready  <= 1'b1;
              state              <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_is_chunker_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if ((TIMEOUT_CYCLES != 0) && (timer == TMAX)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
